// File: rtl/pb_debounce_multi_if.sv
// Button-side bundle for pb_debounce_multi: raw pins and repeat enable
// towards the debouncer, debounced levels and event pulses back out.
interface pb_debounce_multi_if #(
    parameter int N = 4
);
    logic [N-1:0] pb;
    logic         repeat_en;
    logic [N-1:0] pb_state;
    logic [N-1:0] pb_down;
    logic [N-1:0] pb_up;
    logic [N-1:0] pb_rep;
    logic         any_active;

    // Driver side: owns the pins, observes the debounced results.
    modport master (
        output pb,
        output repeat_en,
        input  pb_state,
        input  pb_down,
        input  pb_up,
        input  pb_rep,
        input  any_active
    );

    // Debouncer side.
    modport slave (
        input  pb,
        input  repeat_en,
        output pb_state,
        output pb_down,
        output pb_up,
        output pb_rep,
        output any_active
    );
endinterface

// File: rtl/pb_debounce_multi.sv
// pb_debounce_multi: N independent push-button channels, each with a 2-FF
// synchroniser, an equality-compared debounce counter (any agreeing cycle
// discards progress) and a delay/period auto-repeat generator. Every output
// is a flop; nothing combinational reaches the outputs from the pins.
module pb_debounce_multi #(
    parameter int N             = 4,
    parameter int DEB_CYCLES    = 50000,
    parameter int ACTIVE_LOW    = 1,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input logic                clk,
    input logic                rst_n,
    pb_debounce_multi_if.slave bus
);
    localparam int CNT_W  = $clog2(DEB_CYCLES);
    localparam int RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCNT_W = $clog2(RMAX);

    localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [RCNT_W-1:0] RDLY_LAST = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] RPER_LAST = RCNT_W'(REPEAT_PERIOD - 1);

    // Pins normalised so that 1 always means "pressed"; reset value 0 of the
    // synchroniser therefore reads as released.
    logic [N-1:0] raw_s;

    logic [N-1:0] sync0_q, sync1_q;
    logic [N-1:0] state_q, state_d;
    logic [N-1:0] down_q, down_d;
    logic [N-1:0] up_q, up_d;
    logic [N-1:0] rep_q, rep_d;
    logic [N-1:0] phase_q, phase_d;
    logic [N-1:0] flip_s;
    logic         any_q, any_d;
    logic [CNT_W-1:0]  cnt_q [N];
    logic [CNT_W-1:0]  cnt_d [N];
    logic [RCNT_W-1:0] rcnt_q [N];
    logic [RCNT_W-1:0] rcnt_d [N];

    assign raw_s = (ACTIVE_LOW != 0) ? ~bus.pb : bus.pb;

    // Debounce and auto-repeat next-state for every channel.
    always_comb begin
        state_d = state_q;
        down_d  = {N{1'b0}};
        up_d    = {N{1'b0}};
        rep_d   = {N{1'b0}};
        phase_d = phase_q;
        flip_s  = {N{1'b0}};
        any_d   = |state_q;
        for (int c = 0; c < N; c++) begin
            cnt_d[c]  = cnt_q[c];
            rcnt_d[c] = rcnt_q[c];
        end
        for (int c = 0; c < N; c++) begin
            // Level acceptance: DEB_CYCLES consecutive disagreeing samples.
            if (sync1_q[c] == state_q[c]) begin
                cnt_d[c] = {CNT_W{1'b0}};
            end else if (cnt_q[c] == DEB_LAST) begin
                cnt_d[c]   = {CNT_W{1'b0}};
                flip_s[c]  = 1'b1;
                state_d[c] = ~state_q[c];
                down_d[c]  = ~state_q[c];
                up_d[c]    = state_q[c];
            end else begin
                cnt_d[c] = cnt_q[c] + CNT_W'(1);
            end

            // Repeat is held cleared while released, on either accepted edge
            // (so no repeat lands on a down or up pulse) and while disabled.
            if (!state_q[c] || flip_s[c] || !bus.repeat_en) begin
                rcnt_d[c]  = {RCNT_W{1'b0}};
                phase_d[c] = 1'b0;
            end else if (!phase_q[c] && (rcnt_q[c] == RDLY_LAST)) begin
                rep_d[c]   = 1'b1;
                rcnt_d[c]  = {RCNT_W{1'b0}};
                phase_d[c] = 1'b1;
            end else if (phase_q[c] && (rcnt_q[c] == RPER_LAST)) begin
                rep_d[c]  = 1'b1;
                rcnt_d[c] = {RCNT_W{1'b0}};
            end else begin
                rcnt_d[c] = rcnt_q[c] + RCNT_W'(1);
            end
        end
    end

    // State registers; reset loads every stage with the released value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_q <= {N{1'b0}};
            sync1_q <= {N{1'b0}};
            state_q <= {N{1'b0}};
            down_q  <= {N{1'b0}};
            up_q    <= {N{1'b0}};
            rep_q   <= {N{1'b0}};
            phase_q <= {N{1'b0}};
            any_q   <= 1'b0;
            for (int c = 0; c < N; c++) begin
                cnt_q[c]  <= {CNT_W{1'b0}};
                rcnt_q[c] <= {RCNT_W{1'b0}};
            end
        end else begin
            sync0_q <= raw_s;
            sync1_q <= sync0_q;
            state_q <= state_d;
            down_q  <= down_d;
            up_q    <= up_d;
            rep_q   <= rep_d;
            phase_q <= phase_d;
            any_q   <= any_d;
            for (int c = 0; c < N; c++) begin
                cnt_q[c]  <= cnt_d[c];
                rcnt_q[c] <= rcnt_d[c];
            end
        end
    end

    assign bus.pb_state   = state_q;
    assign bus.pb_down    = down_q;
    assign bus.pb_up      = up_q;
    assign bus.pb_rep     = rep_q;
    assign bus.any_active = any_q;

endmodule

// File: tb/tb_pb_debounce_multi.sv
// Bench for pb_debounce_multi: directed scenarios plus a randomized phase,
// checked every cycle against a sliding-window / elapsed-time reference model.
module tb_pb_debounce_multi;
    localparam int N   = 4;
    localparam int DEB = 8;
    localparam int RD  = 20;
    localparam int RP  = 5;

    logic clk = 1'b0;
    logic rst_n;

    pb_debounce_multi_if #(.N(N)) bus ();

    pb_debounce_multi #(
        .N(N), .DEB_CYCLES(DEB), .ACTIVE_LOW(1),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state.
    logic [N-1:0] hist_q[$];
    logic [N-1:0] m_state, m_down, m_up, m_rep;
    logic         m_any;
    int           last_clr[N];
    int           edge_k = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_k);
        end
    endtask

    task automatic model_reset();
        m_state = '0; m_down = '0; m_up = '0; m_rep = '0; m_any = 1'b0;
        hist_q = {};
        for (int i = 0; i < DEB + 2; i++) hist_q.push_back('0);
        for (int c = 0; c < N; c++) last_clr[c] = edge_k;
    endtask

    // One rising edge: a level is accepted once the DEB newest synchronised
    // samples (pin values from 2..DEB+1 edges ago) all differ from it; a
    // repeat fires at RD, RD+RP, ... edges after the last edge that cleared it.
    task automatic model_edge(input logic [N-1:0] raw_v, input logic ren_v);
        logic [N-1:0] old_v;
        bit           all_diff;
        int           el;
        old_v = m_state;
        hist_q.push_back(raw_v);
        while (hist_q.size() > DEB + 2) void'(hist_q.pop_front());
        edge_k++;
        m_any = |old_v;
        for (int c = 0; c < N; c++) begin
            all_diff = 1'b1;
            for (int i = 0; i < DEB; i++)
                if (hist_q[i][c] == old_v[c]) all_diff = 1'b0;
            m_down[c]  = all_diff & ~old_v[c];
            m_up[c]    = all_diff & old_v[c];
            m_state[c] = old_v[c] ^ all_diff;
            if (!old_v[c] || all_diff || !ren_v) begin
                last_clr[c] = edge_k;
                m_rep[c]    = 1'b0;
            end else begin
                el       = edge_k - last_clr[c];
                m_rep[c] = (el >= RD) && (((el - RD) % RP) == 0);
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check_val({tag, ".state"}, 32'(bus.pb_state), 32'(m_state));
        check_val({tag, ".down"},  32'(bus.pb_down),  32'(m_down));
        check_val({tag, ".up"},    32'(bus.pb_up),    32'(m_up));
        check_val({tag, ".rep"},   32'(bus.pb_rep),   32'(m_rep));
        check_val({tag, ".any"},   32'(bus.any_active), 32'(m_any));
    endtask

    // Called just after a falling edge: drive, take the rising edge, compare.
    task automatic tick(input logic [N-1:0] pb_v, input logic ren_v);
        bus.pb        = pb_v;
        bus.repeat_en = ren_v;
        @(posedge clk);
        #1;
        model_edge(~pb_v, ren_v);
        compare_all("cyc");
        @(negedge clk);
    endtask

    int           start_e, down_at, up_at, rep_at, n_down;
    bit           saw_all;
    logic [N-1:0] lvl;
    int           rem[N];
    logic         ren;

    initial begin
        // Reset state.
        rst_n = 1'b0;
        bus.pb = '1;
        bus.repeat_en = 1'b0;
        model_reset();
        #3;
        compare_all("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick(4'hF, 1'b0);

        // Clean press/release on channel 0, with latency measured directly.
        start_e = edge_k + 1; down_at = -1;
        for (int i = 0; i < 40; i++) begin
            tick(4'b1110, 1'b0);
            if (bus.pb_down[0] && down_at < 0) down_at = edge_k;
        end
        check_val("press_latency", 32'(down_at - start_e + 1), 32'(DEB + 2));
        start_e = edge_k + 1; up_at = -1;
        for (int i = 0; i < 20; i++) begin
            tick(4'hF, 1'b0);
            if (bus.pb_up[0] && up_at < 0) up_at = edge_k;
        end
        check_val("release_latency", 32'(up_at - start_e + 1), 32'(DEB + 2));

        // Bounce rejection on channel 1: runs of 3, 5, 7 never reach DEB.
        lvl = 4'hF;
        for (int seg = 0; seg < 3; seg++)
            for (int i = 0; i < 20; i++) begin
                if ((i % (3 + 2 * seg)) == 0) lvl[1] = ~lvl[1];
                tick(lvl, 1'b0);
                check_val("bounce_state", 32'(bus.pb_state), 32'h0);
            end
        for (int i = 0; i < 20; i++) tick(4'hF, 1'b0);

        // Random bounce on channel 2, then settle low.
        lvl = 4'hF;
        for (int i = 0; i < 20; i += 0) begin
            lvl[2] = ~lvl[2];
            for (int j = $urandom_range(1, 3); j > 0; j--) begin tick(lvl, 1'b0); i++; end
        end
        lvl[2] = 1'b0;
        start_e = edge_k + 1; n_down = 0; down_at = -1;
        for (int i = 0; i < 30; i++) begin
            tick(lvl, 1'b0);
            if (bus.pb_down[2]) begin n_down++; down_at = edge_k; end
        end
        check_val("settle_downs", 32'(n_down), 32'd1);
        check_val("settle_latency", 32'(down_at - start_e + 1), 32'(DEB + 2));
        for (int i = 0; i < 20; i++) tick(4'hF, 1'b0);

        // Auto-repeat on channel 3, then the same hold with repeat disabled.
        down_at = -1; rep_at = -1;
        for (int i = 0; i < 72; i++) begin
            tick(4'b0111, 1'b1);
            if (bus.pb_down[3]) down_at = edge_k;
            if (bus.pb_rep[3] && rep_at < 0) rep_at = edge_k;
        end
        check_val("first_rep", 32'(rep_at - down_at), 32'(RD));
        for (int i = 0; i < 20; i++) tick(4'hF, 1'b1);
        for (int i = 0; i < 72; i++) begin
            tick(4'b0111, 1'b0);
            check_val("rep_disabled", 32'(bus.pb_rep), 32'h0);
        end
        for (int i = 0; i < 20; i++) tick(4'hF, 1'b0);

        // Simultaneous press of every channel.
        saw_all = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(4'h0, 1'b0);
            if (bus.pb_down == 4'hF) saw_all = 1'b1;
        end
        check_val("all_down", 32'(saw_all), 32'd1);
        for (int i = 0; i < 20; i++) tick(4'hF, 1'b0);

        // Reset during the repeat phase; button still held afterwards.
        for (int i = 0; i < 40; i++) tick(4'b0111, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("midreset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        down_at = -1; rep_at = -1;
        for (int i = 0; i < 50; i++) begin
            tick(4'b0111, 1'b1);
            if (bus.pb_down[3]) down_at = edge_k;
            if (bus.pb_rep[3] && rep_at < 0) rep_at = edge_k;
        end
        check_val("reacc_latency", 32'(down_at - edge_k + 50), 32'(DEB + 2));
        check_val("reacc_first_rep", 32'(rep_at - down_at), 32'(RD));
        for (int i = 0; i < 20; i++) tick(4'hF, 1'b1);

        // Randomized phase: independent hold lengths, occasional bounces,
        // repeat enable toggling mid-hold.
        lvl = 4'hF; ren = 1'b1;
        for (int c = 0; c < N; c++) rem[c] = $urandom_range(1, 30);
        for (int t = 0; t < 800; t++) begin
            for (int c = 0; c < N; c++) begin
                if (rem[c] == 0) begin
                    lvl[c] = ~lvl[c];
                    rem[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4)
                                                         : $urandom_range(8, 45);
                end else begin
                    rem[c]--;
                end
            end
            if ($urandom_range(0, 59) == 0) ren = ~ren;
            tick(lvl, ren);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation did not complete");
    end
endmodule
